// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi decoder: default geometry, encoder tap
// parity, modulo path-metric comparison and the controller state encoding.
package viterbi_pkg;

  localparam int K_DEF = 5;
  localparam int NS    = 1 << (K_DEF - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACS,
    ST_TB,
    ST_OUT
  } vit_state_t;

  // Encoder output bit for input u leaving 'state' (state holds the K-1
  // previous inputs, newest at bit k-2); g is the generator, MSB = input tap.
  function automatic logic parity_out(input logic [7:0] state, input logic u,
                                      input logic [7:0] g, input int k);
    return ^((state | (8'(u) << (k - 1))) & g);
  endfunction

  // Metrics wrap, so "a better than b" is the sign of (a - b) at width w.
  function automatic logic pm_better(input logic [15:0] a, input logic [15:0] b,
                                     input int w);
    return 1'((a - b) >> (w - 1));
  endfunction

endpackage

// File: rtl/viterbi_acs_unit.sv
// Two-way add-compare-select for one trellis state. Ties keep predecessor 0.
module viterbi_acs_unit
  import viterbi_pkg::*;
#(
  parameter int PM_W = 8
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [PM_W-1:0] bm0,
  input  logic [PM_W-1:0] bm1,
  output logic [PM_W-1:0] pm_new,
  output logic            dec
);

  logic [PM_W-1:0] cand0;
  logic [PM_W-1:0] cand1;

  // Add both branches, pick the strictly better one, report which.
  always_comb begin
    cand0  = pm0 + bm0;
    cand1  = pm1 + bm1;
    dec    = pm_better(16'(cand1), 16'(cand0), PM_W);
    pm_new = dec ? cand1 : cand0;
  end

endmodule

// File: rtl/viterbi_core.sv
// Rate-1/2 Viterbi decoder: parallel ACS over all states, circular survivor
// memory of D_TB rows, serial traceback emitting one bit per symbol pair.
//
//   state   | meaning
//   IDLE    | sym_ready high, waiting for a symbol pair
//   ACS     | update metrics, write survivor row, advance wp/fill
//   TB      | D_TB+1 cycles: load argmin, then D_TB traceback steps
//   OUT     | bit_valid high until bit_ready
module viterbi_core
  import viterbi_pkg::*;
#(
  parameter int K      = 5,
  parameter int D_TB   = 32,
  parameter int G0_OCT = 'o23,
  parameter int G1_OCT = 'o35,
  parameter int SOFT_W = 3,
  parameter int PM_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic              sym_first,
  input  logic [SOFT_W-1:0] sym0,
  input  logic [SOFT_W-1:0] sym1,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              bit_out
);

  localparam int S_W  = K - 1;
  localparam int NS_L = 1 << S_W;
  localparam int WP_W = $clog2(D_TB);
  localparam int F_W  = $clog2(D_TB + 2);
  localparam int TC_W = $clog2(D_TB + 1);
  localparam logic [PM_W-1:0]   PM_INIT  = PM_W'(1 << (PM_W - 2));
  localparam logic [SOFT_W:0]   MAX_S    = {1'b0, {SOFT_W{1'b1}}};
  localparam logic [F_W-1:0]    FILL_MAX = F_W'(D_TB + 1);
  localparam logic [WP_W-1:0]   ROW_LAST = WP_W'(D_TB - 1);
  localparam logic [TC_W-1:0]   TB_LAST  = TC_W'(D_TB);
  localparam logic [7:0]        G0_V     = 8'(G0_OCT);
  localparam logic [7:0]        G1_V     = 8'(G1_OCT);

  vit_state_t        state, state_nx;
  logic [PM_W-1:0]   pm     [NS_L];
  logic [PM_W-1:0]   pm_src [NS_L];
  logic [PM_W-1:0]   pm_acs [NS_L];
  logic [NS_L-1:0]   dec;
  logic [NS_L-1:0]   surv   [D_TB];
  logic [WP_W-1:0]   wp, tb_row;
  logic [F_W-1:0]    fill, fill_base, fill_nx;
  logic [TC_W-1:0]   tb_cnt;
  logic [SOFT_W-1:0] s0_q, s1_q;
  logic              first_q;
  logic [S_W-1:0]    cursor, cursor_step, best;
  logic              sym_hs;

  assign sym_hs      = sym_valid & sym_ready;
  assign cursor_step = {cursor[S_W-2:0], surv[tb_row][cursor]};

  // A frame start presents the initial metrics to the ACS array.
  always_comb begin
    for (int i = 0; i < NS_L; i++) begin
      pm_src[i] = first_q ? ((i == 0) ? '0 : PM_INIT) : pm[i];
    end
  end

  for (genvar n = 0; n < NS_L; n++) begin : g_acs
    localparam int         P0  = (n << 1) & (NS_L - 1);
    localparam int         P1  = P0 | 1;
    localparam logic [7:0] ST0 = 8'(P0);
    localparam logic [7:0] ST1 = 8'(P1);
    localparam logic       U   = 1'(n >> (K - 2));
    logic [SOFT_W:0] t00, t01, t10, t11;
    logic [PM_W-1:0] bm0, bm1;

    // Branch metrics of the two transitions entering state n.
    always_comb begin
      t00 = parity_out(ST0, U, G0_V, K) ? MAX_S - {1'b0, s0_q} : {1'b0, s0_q};
      t01 = parity_out(ST0, U, G1_V, K) ? MAX_S - {1'b0, s1_q} : {1'b0, s1_q};
      t10 = parity_out(ST1, U, G0_V, K) ? MAX_S - {1'b0, s0_q} : {1'b0, s0_q};
      t11 = parity_out(ST1, U, G1_V, K) ? MAX_S - {1'b0, s1_q} : {1'b0, s1_q};
      bm0 = PM_W'(t00 + t01);
      bm1 = PM_W'(t10 + t11);
    end

    viterbi_acs_unit #(.PM_W(PM_W)) u_acs (
      .pm0   (pm_src[P0]),
      .pm1   (pm_src[P1]),
      .bm0   (bm0),
      .bm1   (bm1),
      .pm_new(pm_acs[n]),
      .dec   (dec[n])
    );
  end

  // Best current state under modulo compare; lowest index wins ties.
  always_comb begin
    best = '0;
    for (int i = 1; i < NS_L; i++) begin
      if (pm_better(16'(pm[i]), 16'(pm[best]), PM_W)) best = S_W'(i);
    end
  end

  // Symbol count after this ACS, restarting on a frame start, saturating.
  always_comb begin
    fill_base = first_q ? '0 : fill;
    fill_nx   = (fill_base >= FILL_MAX) ? fill_base : fill_base + F_W'(1);
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (sym_hs) state_nx = ST_ACS;
      ST_ACS:  state_nx = (fill_nx >= FILL_MAX) ? ST_TB : ST_IDLE;
      ST_TB:   if (tb_cnt == TB_LAST) state_nx = ST_OUT;
      ST_OUT:  if (bit_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Control state, metrics, pointers and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sym_ready <= 1'b0;
      bit_valid <= 1'b0;
      bit_out   <= 1'b0;
      fill      <= '0;
      wp        <= '0;
      tb_row    <= '0;
      tb_cnt    <= '0;
      first_q   <= 1'b0;
      for (int i = 0; i < NS_L; i++) pm[i] <= (i == 0) ? '0 : PM_INIT;
    end else begin
      state     <= state_nx;
      sym_ready <= (state_nx == ST_IDLE);
      bit_valid <= (state_nx == ST_OUT);
      case (state)
        ST_IDLE: if (sym_hs) first_q <= sym_first;
        ST_ACS: begin
          pm     <= pm_acs;
          fill   <= fill_nx;
          wp     <= (wp == ROW_LAST) ? '0 : wp + WP_W'(1);
          tb_row <= wp;
          tb_cnt <= '0;
        end
        ST_TB: begin
          tb_cnt <= tb_cnt + TC_W'(1);
          if (tb_cnt != '0) tb_row <= (tb_row == '0) ? ROW_LAST : tb_row - WP_W'(1);
          if (tb_cnt == TB_LAST) bit_out <= cursor_step[S_W-1];
        end
        default: ;
      endcase
    end
  end

  // Datapath registers that need no reset: symbol latch, survivors, cursor.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && sym_hs) begin
      s0_q <= sym0;
      s1_q <= sym1;
    end
    if (state == ST_ACS) surv[wp] <= dec;
    if (state == ST_TB) cursor <= (tb_cnt == '0) ? best : cursor_step;
  end

endmodule

// File: tb/tb_viterbi_core.sv
// Randomised bench for viterbi_core against an integer trellis model that
// keeps the full decision history of the current frame.
module tb_viterbi_core;

  localparam int K    = 5;
  localparam int D_TB = 32;
  localparam int G0   = 'o23;
  localparam int G1   = 'o35;
  localparam int NS   = 16;
  localparam int MAXS = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sym_valid = 1'b0;
  logic       sym_ready;
  logic       sym_first = 1'b0;
  logic [2:0] sym0 = '0;
  logic [2:0] sym1 = '0;
  logic       bit_valid;
  logic       bit_ready = 1'b1;
  logic       bit_out;

  int n_tests = 0;
  int n_fail  = 0;

  int          pm_m [NS];
  int unsigned hist [$];
  int          fill_m = 0;
  int          enc_st = 0;

  viterbi_core dut (
    .clk(clk), .rst(rst),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_first(sym_first),
    .sym0(sym0), .sym1(sym1),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_out(bit_out)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int par(input int r, input int g);
    return $countones(r & g) & 1;
  endfunction

  task automatic encode(input int u, output int c0, output int c1);
    int r;
    r      = (u << (K - 1)) | enc_st;
    c0     = par(r, G0);
    c1     = par(r, G1);
    enc_st = r >> 1;
  endtask

  function automatic int noisy(input int c);
    int v;
    v = c * MAXS + int'($urandom_range(0, 4)) + int'($urandom_range(0, 4)) - 4;
    if (v < 0) v = 0;
    if (v > MAXS) v = MAXS;
    return v;
  endfunction

  // Reference decoder: unbounded integer metrics, min-select, full traceback.
  task automatic model_step(input int a, input int b, input bit first,
                            output bit has, output bit exp);
    int npm [NS];
    int unsigned mask;
    int u, p, r, bm, c, st;
    has = 1'b0;
    exp = 1'b0;
    if (first) begin
      for (int i = 0; i < NS; i++) pm_m[i] = (i == 0) ? 0 : 64;
      hist.delete();
      fill_m = 0;
    end
    mask = 0;
    for (int n = 0; n < NS; n++) begin
      u = n >> (K - 2);
      npm[n] = 0;
      for (int x = 0; x < 2; x++) begin
        p  = ((n << 1) & (NS - 1)) | x;
        r  = (u << (K - 1)) | p;
        bm = (par(r, G0) != 0 ? MAXS - a : a) + (par(r, G1) != 0 ? MAXS - b : b);
        c  = pm_m[p] + bm;
        if (x == 0) npm[n] = c;
        else if (c < npm[n]) begin
          npm[n] = c;
          mask |= (32'd1 << n);
        end
      end
    end
    pm_m = npm;
    hist.push_back(mask);
    if (hist.size() > D_TB) void'(hist.pop_front());
    fill_m++;
    if (fill_m >= D_TB + 1) begin
      has = 1'b1;
      st  = 0;
      for (int i = 1; i < NS; i++) if (pm_m[i] < pm_m[st]) st = i;
      for (int j = 0; j < D_TB; j++) st = ((st << 1) & (NS - 1)) | int'((hist[D_TB - 1 - j] >> st) & 1);
      exp = bit'(st >> (K - 2));
    end
  endtask

  // One symbol pair through the DUT; called and returns at a negedge.
  task automatic push(input int a, input int b, input bit first, input int hold,
                      input bit abort, output bit got, output bit bv);
    bit has, exp, b0;
    int cyc;
    got = 1'b0;
    bv  = 1'b0;
    model_step(a, b, first, has, exp);
    sym0 = 3'(a);
    sym1 = 3'(b);
    sym_first = first;
    sym_valid = 1'b1;
    cyc = 0;
    while (!sym_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!sym_ready) begin
      check_val("sym_ready_timeout", 0, 1);
      sym_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    sym_valid = 1'b0;
    sym_first = 1'b0;
    cyc = 1;
    if (!has) begin
      while (!sym_ready && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      check_val("warmup_period", cyc, 2);
      check_val("warmup_no_bit", bit_valid, 0);
      return;
    end
    while (!bit_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_val("bit_latency", cyc, D_TB + 3);
    if (!bit_valid) return;
    if (abort) begin
      rst = 1'b1;
      #1;
      check_val("abort_bit_valid", bit_valid, 0);
      check_val("abort_sym_ready", sym_ready, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("abort_sym_ready_back", sym_ready, 1);
      return;
    end
    if (hold > 0) begin
      bit_ready = 1'b0;
      b0 = bit_out;
      repeat (hold) begin
        @(negedge clk);
        check_val("bp_bit_valid", bit_valid, 1);
        check_val("bp_bit_stable", bit_out, b0);
        check_val("bp_sym_ready", sym_ready, 0);
      end
      bit_ready = 1'b1;
    end
    check_val("bit_vs_model", bit_out, exp);
    got = 1'b1;
    bv  = bit_out;
    @(posedge clk);
    @(negedge clk);
    check_val("bit_valid_drop", bit_valid, 0);
    check_val("sym_ready_after_bit", sym_ready, 1);
  endtask

  // mode: 0 strong, 1 three inversions, 2 three erasures, 3 noisy, 4 all-zero
  task automatic run_frame(input int nsym, input int mode, input int bp_at,
                           input int abort_at, output int nbits);
    int ubits [$];
    int u, c0, c1, a, b;
    bit got, bv;
    nbits  = 0;
    enc_st = 0;
    for (int t = 0; t < nsym; t++) begin
      u = (mode == 4) ? 0 : int'($urandom_range(0, 1));
      ubits.push_back(u);
      encode(u, c0, c1);
      a = c0 * MAXS;
      b = c1 * MAXS;
      if (mode == 1 && (t == 50 || t == 90 || t == 130)) a = MAXS - a;
      if (mode == 2 && (t == 50 || t == 90 || t == 130)) a = (t == 90) ? 4 : 3;
      if (mode == 3) begin
        a = noisy(c0);
        b = noisy(c1);
      end
      push(a, b, (t == 0), (t == bp_at) ? 10 : 0, (t == abort_at), got, bv);
      if (t == abort_at) return;
      if (got) begin
        nbits++;
        if (mode != 3) check_val("bit_vs_input", bv, ubits[t - D_TB]);
      end
    end
  endtask

  initial begin
    int nb;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_sym_ready", sym_ready, 0);
    check_val("rst_bit_valid", bit_valid, 0);
    check_val("rst_bit_out", bit_out, 0);
    rst = 1'b0;
    #1;
    check_val("sym_ready_before_edge", sym_ready, 0);
    @(negedge clk);
    check_val("sym_ready_after_edge", sym_ready, 1);
    check_val("bit_valid_idle", bit_valid, 0);
    check_val("pm0_reset", int'(dut.pm[0]), 0);
    check_val("pm15_reset", int'(dut.pm[15]), 64);

    run_frame(40, 4, -1, -1, nb);
    check_val("zero_frame_bits", nb, 8);
    run_frame(32, 0, -1, -1, nb);
    check_val("short_frame_bits", nb, 0);
    run_frame(200, 0, 100, -1, nb);
    check_val("strong_frame_bits", nb, 168);
    run_frame(200, 1, -1, -1, nb);
    check_val("inversion_frame_bits", nb, 168);
    run_frame(200, 2, -1, -1, nb);
    check_val("erasure_frame_bits", nb, 168);
    run_frame(40, 0, -1, 35, nb);
    check_val("pre_abort_bits", nb, 3);
    run_frame(60, 0, -1, -1, nb);
    check_val("post_abort_bits", nb, 28);
    run_frame(1200, 3, -1, -1, nb);
    check_val("noisy_frame_bits", nb, 1168);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
